// File: rtl/adc_scan_sequencer.sv
// Scan/host sequencer for an ADC0809-style converter: drives address/ALE/START/OE,
// waits on a synchronised EOC and publishes one result per conversion.
module adc_scan_sequencer #(
  parameter int NUM_CH      = 4,
  parameter int ADC_DIV     = 50,
  parameter int SETUP       = 2,
  parameter int EOC_TIMEOUT = 4096
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       host_req,
  input  logic [2:0] host_ch,
  output logic       host_ack,
  input  logic       eoc,
  input  logic [7:0] adc_data,
  output logic       adc_clock,
  output logic       ale,
  output logic       start,
  output logic       oe,
  output logic [2:0] address,
  output logic [7:0] result_data,
  output logic [2:0] result_ch,
  output logic       result_valid,
  output logic       timeout_err
);

  localparam int DIV_W = (ADC_DIV > 1) ? $clog2(ADC_DIV) : 1;
  localparam int TO_W  = $clog2(EOC_TIMEOUT + 2*ADC_DIV + 1);
  localparam int CNT_W = $clog2(SETUP + 2);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(ADC_DIV - 1);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(EOC_TIMEOUT - 1);
  localparam logic [TO_W-1:0]  START_LAST = TO_W'(2*ADC_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP - 1);
  localparam logic [2:0]       CH_LAST    = 3'(NUM_CH - 1);
  localparam logic [3:0]       NUM_CH_W   = 4'(NUM_CH);

  typedef enum logic [2:0] {
    S_IDLE, S_SEL, S_ALE, S_START, S_WAIT_LO, S_WAIT_HI, S_READ, S_DONE
  } state_t;

  // Free-running conversion clock divider
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             adc_clk_q, adc_clk_d;
  logic             eoc_m_q, eoc_m_d, eoc_s_q, eoc_s_d;

  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    adc_clk_d = adc_clk_q;
    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
      adc_clk_d = ~adc_clk_q;
    end
    eoc_m_d = eoc;
    eoc_s_d = eoc_m_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt_q <= '0;
      adc_clk_q <= 1'b0;
      eoc_m_q   <= 1'b0;
      eoc_s_q   <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      adc_clk_q <= adc_clk_d;
      eoc_m_q   <= eoc_m_d;
      eoc_s_q   <= eoc_s_d;
    end
  end

  state_t           state_q;
  logic [2:0]       ptr_q, address_q, result_ch_q;
  logic             host_job_q;
  logic [CNT_W-1:0] cnt_q;
  logic [TO_W-1:0]  tcnt_q;
  logic             ale_q, start_q, oe_q;
  logic [7:0]       result_data_q;
  logic             result_valid_q, timeout_err_q, host_ack_q;
  logic             to_hit;

  assign to_hit = (tcnt_q == TO_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      ptr_q          <= '0;
      host_job_q     <= 1'b0;
      address_q      <= '0;
      cnt_q          <= '0;
      tcnt_q         <= '0;
      ale_q          <= 1'b0;
      start_q        <= 1'b0;
      oe_q           <= 1'b0;
      result_data_q  <= '0;
      result_ch_q    <= '0;
      result_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      host_ack_q     <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      host_ack_q     <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (host_req) begin
            host_job_q <= 1'b1;
            // Out-of-range host channel is refused without touching the ADC pins
            if ({1'b0, host_ch} >= NUM_CH_W) begin
              host_ack_q    <= 1'b1;
              timeout_err_q <= 1'b1;
              state_q       <= S_DONE;
            end else begin
              address_q <= host_ch;
              cnt_q     <= '0;
              state_q   <= S_SEL;
            end
          end else if (enable) begin
            host_job_q <= 1'b0;
            address_q  <= ptr_q;
            cnt_q      <= '0;
            state_q    <= S_SEL;
          end
        end
        S_SEL: begin
          if (cnt_q == SETUP_LAST) begin
            ale_q   <= 1'b1;
            state_q <= S_ALE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_ALE: begin
          ale_q   <= 1'b0;
          start_q <= 1'b1;
          tcnt_q  <= '0;
          state_q <= S_START;
        end
        S_START, S_WAIT_LO, S_WAIT_HI: begin
          tcnt_q <= tcnt_q + 1'b1;
          if (to_hit) begin
            start_q       <= 1'b0;
            timeout_err_q <= 1'b1;
            host_ack_q    <= host_job_q;
            state_q       <= S_DONE;
          end else if (state_q == S_START) begin
            if (tcnt_q == START_LAST) begin
              start_q <= 1'b0;
              state_q <= S_WAIT_LO;
            end
          end else if (state_q == S_WAIT_LO) begin
            if (!eoc_s_q) state_q <= S_WAIT_HI;
          end else if (eoc_s_q) begin
            oe_q    <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_READ;
          end
        end
        S_READ: begin
          if (cnt_q == CNT_W'(1)) begin
            oe_q           <= 1'b0;
            result_data_q  <= adc_data;
            result_ch_q    <= address_q;
            result_valid_q <= 1'b1;
            host_ack_q     <= host_job_q;
            state_q        <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          if (!host_job_q) ptr_q <= (ptr_q == CH_LAST) ? 3'd0 : ptr_q + 3'd1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign adc_clock    = adc_clk_q;
  assign ale          = ale_q;
  assign start        = start_q;
  assign oe           = oe_q;
  assign address      = address_q;
  assign result_data  = result_data_q;
  assign result_ch    = result_ch_q;
  assign result_valid = result_valid_q;
  assign timeout_err  = timeout_err_q;
  assign host_ack     = host_ack_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench: a 4-channel instance for scan/timing/timeout/reset/illegal-host
// and an 8-channel instance for host priority, each with a simple ADC model.
module tb_adc_scan_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic       en4, hreq4, hack4, eoc4, aclk4, ale4, start4, oe4, rvld4, terr4, tie4;
  logic [2:0] hch4, addr4, rch4;
  logic [7:0] data4, rdata4;
  logic       en8, hreq8, hack8, eoc8, aclk8, ale8, start8, oe8, rvld8, terr8;
  logic [2:0] hch8, addr8, rch8;
  logic [7:0] data8, rdata8;

  adc_scan_sequencer #(.NUM_CH(4), .ADC_DIV(4), .SETUP(2), .EOC_TIMEOUT(64)) u_dut4 (
    .clock(clk), .reset(rst_n), .enable(en4), .host_req(hreq4), .host_ch(hch4),
    .host_ack(hack4), .eoc(eoc4), .adc_data(data4), .adc_clock(aclk4), .ale(ale4),
    .start(start4), .oe(oe4), .address(addr4), .result_data(rdata4), .result_ch(rch4),
    .result_valid(rvld4), .timeout_err(terr4));

  adc_scan_sequencer #(.NUM_CH(8), .ADC_DIV(4), .SETUP(2), .EOC_TIMEOUT(64)) u_dut8 (
    .clock(clk), .reset(rst_n), .enable(en8), .host_req(hreq8), .host_ch(hch8),
    .host_ack(hack8), .eoc(eoc8), .adc_data(data8), .adc_clock(aclk8), .ale(ale8),
    .start(start8), .oe(oe8), .address(addr8), .result_data(rdata8), .result_ch(rch8),
    .result_valid(rvld8), .timeout_err(terr8));

  // ADC model: EOC low from START until 12 cycles after START falls; data = 0x10 + channel
  int cnt4 = 0, cnt8 = 0;
  always @(posedge clk) begin
    if (start4) cnt4 <= 12; else if (cnt4 > 0) cnt4 <= cnt4 - 1;
    if (start8) cnt8 <= 12; else if (cnt8 > 0) cnt8 <= cnt8 - 1;
  end
  assign eoc4  = !tie4 && !start4 && (cnt4 == 0);
  assign eoc8  = !start8 && (cnt8 == 0);
  assign data4 = oe4 ? (8'h10 + {5'd0, addr4}) : 8'hFF;
  assign data8 = oe8 ? (8'h10 + {5'd0, addr8}) : 8'hFF;

  typedef struct packed {
    logic [2:0] ch;
    logic [7:0] data;
    logic       valid;
    logic       terr;
    logic       hack;
  } ev_t;

  typedef struct {
    string      name;
    logic [2:0] ch;
    logic [7:0] data;
    logic       valid;
    logic       terr;
    logic       hack;
  } vec_t;

  ev_t  ev4[$];
  ev_t  ev8[$];
  vec_t tbl[11];

  always @(negedge clk) begin
    if (rvld4 || terr4 || hack4) ev4.push_back('{rvld4 ? rch4 : addr4, rdata4, rvld4, terr4, hack4});
    if (rvld8 || terr8 || hack8) ev8.push_back('{rvld8 ? rch8 : addr8, rdata8, rvld8, terr8, hack8});
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cmp_ev(input ev_t g, input vec_t e);
    chk({e.name, " ch"}, 32'(g.ch), 32'(e.ch));
    if (e.valid) chk({e.name, " data"}, 32'(g.data), 32'(e.data));
    chk({e.name, " valid"}, 32'(g.valid), 32'(e.valid));
    chk({e.name, " timeout_err"}, 32'(g.terr), 32'(e.terr));
    chk({e.name, " host_ack"}, 32'(g.hack), 32'(e.hack));
  endtask

  initial begin
    int   n, t0;
    logic prev;
    tbl[0]  = '{"scan0",     3'd0, 8'h10, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{"scan1",     3'd1, 8'h11, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{"scan2",     3'd2, 8'h12, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{"scan3",     3'd3, 8'h13, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{"scan0wrap", 3'd0, 8'h10, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{"tmo ch0",   3'd0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{"tmo next",  3'd1, 8'h11, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{"post rst",  3'd0, 8'h10, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{"hp ch1",    3'd1, 8'h11, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{"hp host6",  3'd6, 8'h16, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{"hp ch2",    3'd2, 8'h12, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b1; en4 = 0; hreq4 = 0; hch4 = '0; tie4 = 0; en8 = 0; hreq8 = 0; hch8 = '0;
    #1 rst_n = 1'b0;
    #11;
    chk("reset outs dut4", 32'({start4, oe4, ale4, addr4, rdata4, rch4, rvld4, terr4, hack4, aclk4}), 32'd0);
    chk("reset outs dut8", 32'({start8, oe8, ale8, addr8, rdata8, rch8, rvld8, terr8, hack8, aclk8}), 32'd0);

    // Scan with pin timing measured on the ch1 conversion
    @(negedge clk); rst_n = 1'b1; en4 = 1'b1;
    n = 0; prev = aclk4;
    while (aclk4 == prev && n < 50) begin @(negedge clk); n++; end
    n = 0; prev = aclk4;
    do begin @(negedge clk); n++; end while (aclk4 == prev && n < 50);
    chk("adc_clock half period", 32'(n), 32'd4);
    n = 0;
    while (addr4 != 3'd1 && n < 300) begin @(negedge clk); n++; end
    chk("wait addr ch1", 32'(n < 300), 32'd1);
    n = 0;
    while (!ale4 && n < 20) begin n++; @(negedge clk); end
    chk("setup cycles before ale", 32'(n), 32'd2);
    n = 0;
    while (ale4 && n < 20) begin n++; @(negedge clk); end
    chk("ale width", 32'(n), 32'd1);
    n = 0;
    while (start4 && n < 50) begin n++; @(negedge clk); end
    chk("start width", 32'(n), 32'd8);
    n = 0;
    while (!oe4 && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (oe4 && n < 20) begin n++; @(negedge clk); end
    chk("oe width", 32'(n), 32'd2);
    n = 0;
    while (ev4.size() < 5 && n < 600) begin @(negedge clk); n++; end
    chk("scan event count", 32'(ev4.size() >= 5), 32'd1);
    for (int i = 0; i < 5 && i < ev4.size(); i++) cmp_ev(ev4[i], tbl[i]);
    en4 = 1'b0;

    // EOC stuck low: timeout then the next channel proceeds
    @(negedge clk); rst_n = 1'b0; ev4.delete(); tie4 = 1'b1; en4 = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    n = 0;
    while (!start4 && n < 100) begin @(negedge clk); n++; end
    t0 = cyc;
    n = 0;
    while (!terr4 && n < 200) begin @(negedge clk); n++; end
    chk("timeout latency from start", 32'(cyc - t0), 32'd64);
    tie4 = 1'b0;
    n = 0;
    while (ev4.size() < 2 && n < 300) begin @(negedge clk); n++; end
    chk("timeout event count", 32'(ev4.size() >= 2), 32'd1);
    for (int i = 0; i < 2 && i < ev4.size(); i++) cmp_ev(ev4[i], tbl[5+i]);

    // Reset while ch2 sits in WAIT_HI
    n = 0;
    while (addr4 != 3'd2 && n < 300) begin @(negedge clk); n++; end
    tie4 = 1'b1;
    n = 0;
    while (!start4 && n < 50) begin @(negedge clk); n++; end
    n = 0;
    while (start4 && n < 50) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    chk("pre-reset address ch2", 32'(addr4), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset address", 32'(addr4), 32'd0);
    chk("async reset result_data", 32'(rdata4), 32'd0);
    chk("async reset outs", 32'({start4, oe4, ale4, rch4, rvld4, terr4, hack4, aclk4}), 32'd0);
    ev4.delete();
    @(negedge clk); rst_n = 1'b1; tie4 = 1'b0;
    n = 0;
    while (ev4.size() < 1 && n < 300) begin @(negedge clk); n++; end
    chk("post reset event", 32'(ev4.size() >= 1), 32'd1);
    if (ev4.size() >= 1) cmp_ev(ev4[0], tbl[7]);
    en4 = 1'b0;

    // Illegal host channel
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    hch4 = 3'd5; hreq4 = 1'b1;
    @(negedge clk);
    chk("illegal host_ack", 32'(hack4), 32'd1);
    chk("illegal timeout_err", 32'(terr4), 32'd1);
    chk("illegal result_valid", 32'(rvld4), 32'd0);
    hreq4 = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (start4 || ale4) n++;
      @(negedge clk);
    end
    chk("illegal no start/ale", 32'(n), 32'd0);

    // Host priority on the 8-channel instance
    en8 = 1'b1;
    n = 0;
    while (!(addr8 == 3'd1 && start8) && n < 300) begin @(negedge clk); n++; end
    chk("wait ch1 start dut8", 32'(n < 300), 32'd1);
    ev8.delete(); hch8 = 3'd6; hreq8 = 1'b1;
    n = 0;
    while (!hack8 && n < 300) begin @(negedge clk); n++; end
    hreq8 = 1'b0;
    n = 0;
    while (ev8.size() < 3 && n < 300) begin @(negedge clk); n++; end
    chk("host priority event count", 32'(ev8.size() >= 3), 32'd1);
    for (int i = 0; i < 3 && i < ev8.size(); i++) cmp_ev(ev8[i], tbl[8+i]);
    en8 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
